frame_sram_dp: RTL and testbench
================================

Name: frame_sram_dp

Overview:
- Parametrised dual-port frame-buffer SRAM. One write port and one read port, both on a single clock.
- Adds per-channel (R/G/B) write masking, write-first bypass on address collision, a registered read-valid flag, and a hardware frame-clear sequencer.
- Sits between the pixel producer (image filter/loader) and the pixel consumer (output/display stage). It replaces the single-port 24-bit buffer in new datapaths.

Parameters:
- IMG_W, 1024, frame width in pixels
- IMG_H, 1024, frame height in pixels
- ADDR_SZ, 20, address width; must satisfy 2^ADDR_SZ >= IMG_W*IMG_H
- CH_NUM, 3, colour channels per pixel
- CH_W, 8, bits per channel; pixel width PIX_W = CH_NUM*CH_W (24 by default)

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write request
- wr_addr  in  ADDR_SZ  write pixel address
- wr_mask  in  CH_NUM  per-channel write enable; bit i covers data bits [i*CH_W +: CH_W]
- wr_data  in  PIX_W  write pixel
- rd_en  in  1  read request
- rd_addr  in  ADDR_SZ  read pixel address
- rd_data  out  PIX_W  read pixel; holds its value until the next read completes
- rd_valid  out  1  high for one cycle when rd_data is updated
- clr_start  in  1  one-cycle pulse that starts a frame clear
- clr_value  in  PIX_W  fill pixel; sampled on the accepted clr_start
- clr_busy  out  1  high while the clear is in progress
- clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- DEPTH = IMG_W*IMG_H. The memory array is not reset; its contents are undefined after power-up.
- Reset values: rd_data=0, rd_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0.
- Write: when wr_en=1 and wr_addr<DEPTH, only the channels whose wr_mask bit is 1 are updated at the clock edge. wr_mask=0 is a no-op. A write to wr_addr>=DEPTH is ignored.
- Read latency is 1. With rd_en=1 in cycle N, rd_data and rd_valid=1 appear in cycle N+1. rd_valid is 0 in every cycle not preceded by rd_en.
- A read of rd_addr>=DEPTH returns all zeros, with rd_valid=1.
- Collision (rd_en, wr_en, same in-range address, same cycle): masked channels return the new wr_data (write-first). Unmasked channels return the old contents.
- Clear FSM states are IDLE, CLEAR and DONE:
  - IDLE -> CLEAR on clr_start. This latches clr_value, clears the counter, and sets clr_busy=1 from the next cycle.
  - In CLEAR, one pixel per cycle: mem[cnt] <= latched clr_value (full pixel, ignoring the mask), then cnt++. Exit to DONE after writing cnt=DEPTH-1, so a clear takes exactly DEPTH cycles.
  - DONE: clr_busy=0, clr_done=1 for one cycle, then return to IDLE.
- While clr_busy=1, user writes are dropped (not queued) and clr_start is ignored. User reads are still served with the normal latency.
- A read collision with the clear address follows the same write-first rule as a user write.
- clr_start and wr_en in the same IDLE cycle: the user write is performed, and the clear begins on the following cycle.
- Reset asserted mid-clear: the FSM returns to IDLE immediately and clr_busy drops asynchronously. The memory is left partially cleared, and clr_done is not pulsed.

Optional Feature:
- Macro: FRAME_SRAM_OUTREG_EN.
- When defined: an extra output register stage is added for timing closure. Read latency becomes 2. rd_valid is pipelined alongside the data, and the collision result is taken from the first stage. Both registers reset to 0.
- When undefined: read latency is 1, as described above.

Test Plan:
- Write 24'hA1B2C3 to addr 5 with mask 3'b111; read addr 5 -> cycle+1: rd_data=24'hA1B2C3, rd_valid=1; next idle cycle: rd_valid=0.
- Preload 24'h112233 at addr 7; write 24'hFFFFFF with mask 3'b010 -> subsequent read of addr 7 returns 24'h11FF33.
- Same cycle: write addr 9 = 24'h0000AA (mask 3'b001) and read addr 9, where 24'h123456 is preloaded -> rd_data=24'h1234AA.
- With IMG_W=4, IMG_H=4: pulse clr_start with clr_value=24'h808080 -> clr_busy=1 for 16 cycles, then a single clr_done pulse; reads of 0..15 return 24'h808080; a user write during the clear is lost.
- Reset mid-clear at count 6: clr_busy=0 immediately; addrs 0..5 are cleared and 6..15 keep their old data; a new clr_start is accepted after reset.
- Read of addr DEPTH (out of range) -> rd_data=0, rd_valid=1. With FRAME_SRAM_OUTREG_EN defined, rerun the first test -> response at cycle+2.

Source files
------------

// File: rtl/frame_sram_if.sv
// Pixel bus between the frame buffer and its producer/consumer: the write port,
// the read port with its valid flag, and the frame-clear controls.
interface frame_sram_if #(
  parameter int ADDR_SZ = 20,
  parameter int CH_NUM  = 3,
  parameter int CH_W    = 8
);
  localparam int PIX_W = CH_NUM * CH_W;

  logic               wr_en;
  logic [ADDR_SZ-1:0] wr_addr;
  logic [CH_NUM-1:0]  wr_mask;
  logic [PIX_W-1:0]   wr_data;
  logic               rd_en;
  logic [ADDR_SZ-1:0] rd_addr;
  logic [PIX_W-1:0]   rd_data;
  logic               rd_valid;
  logic               clr_start;
  logic [PIX_W-1:0]   clr_value;
  logic               clr_busy;
  logic               clr_done;

  modport master (
    output wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr, clr_start, clr_value,
    input  rd_data, rd_valid, clr_busy, clr_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_mask, wr_data, rd_en, rd_addr, clr_start, clr_value,
    output rd_data, rd_valid, clr_busy, clr_done
  );
endinterface

// File: rtl/frame_sram_dp.sv
// Dual-port frame buffer: masked writes, write-first read bypass and a frame-clear sequencer.
// Define FRAME_SRAM_OUTREG_EN to add a second read output register (read latency 2).
module frame_sram_dp #(
  parameter int IMG_W   = 1024,
  parameter int IMG_H   = 1024,
  parameter int ADDR_SZ = 20,
  parameter int CH_NUM  = 3,
  parameter int CH_W    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  frame_sram_if.slave   bus
);
  localparam int PIX_W = CH_NUM * CH_W;
  localparam int DEPTH = IMG_W * IMG_H;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_SZ:0]  DEPTH_A  = (ADDR_SZ + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } clr_state_t;

  // Channels selected by mask take the new pixel, the rest keep the old one.
  function automatic logic [PIX_W-1:0] merge_pix(
    input logic [PIX_W-1:0]  old_pix,
    input logic [PIX_W-1:0]  new_pix,
    input logic [CH_NUM-1:0] mask
  );
    logic [PIX_W-1:0] res;
    res = old_pix;
    for (int ch = 0; ch < CH_NUM; ch++) begin
      if (mask[ch]) begin
        res[ch*CH_W +: CH_W] = new_pix[ch*CH_W +: CH_W];
      end else begin
        res[ch*CH_W +: CH_W] = old_pix[ch*CH_W +: CH_W];
      end
    end
    return res;
  endfunction

  logic [PIX_W-1:0]  mem_r [DEPTH];

  clr_state_t        state_r;
  clr_state_t        state_nxt_s;
  logic [IDX_W-1:0]  cnt_r;
  logic [PIX_W-1:0]  clr_val_r;
  logic              clr_busy_r;
  logic              clr_done_r;

  logic              wr_in_range_s;
  logic              wr_act_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic [CH_NUM-1:0] wr_mask_s;
  logic [PIX_W-1:0]  wr_pix_s;

  logic              rd_in_range_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [PIX_W-1:0]  rd_pix_s;
  logic [PIX_W-1:0]  rd_data_r;
  logic              rd_valid_r;

  assign wr_in_range_s = ({1'b0, bus.wr_addr} < DEPTH_A);
  assign rd_in_range_s = ({1'b0, bus.rd_addr} < DEPTH_A);
  assign rd_idx_s      = bus.rd_addr[IDX_W-1:0];

  // Clear sequencer next-state: a clear only starts from idle and runs one pixel per cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_nxt_s = ST_CLEAR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (cnt_r == LAST_IDX) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Clear sequencer state, pixel counter, latched fill value and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      clr_val_r  <= '0;
      clr_busy_r <= 1'b0;
      clr_done_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      clr_busy_r <= (state_nxt_s == ST_CLEAR);
      clr_done_r <= (state_nxt_s == ST_DONE);
      if (state_r == ST_IDLE && bus.clr_start) begin
        cnt_r     <= '0;
        clr_val_r <= bus.clr_value;
      end else if (state_r == ST_CLEAR) begin
        cnt_r <= cnt_r + IDX_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // The single array write port is owned by the clear while it runs; user writes are dropped.
  always_comb begin
    wr_act_s  = 1'b0;
    wr_idx_s  = '0;
    wr_mask_s = '0;
    wr_pix_s  = '0;
    if (state_r == ST_CLEAR) begin
      wr_act_s  = 1'b1;
      wr_idx_s  = cnt_r;
      wr_mask_s = '1;
      wr_pix_s  = clr_val_r;
    end else begin
      wr_act_s  = bus.wr_en && wr_in_range_s && (|bus.wr_mask);
      wr_idx_s  = bus.wr_addr[IDX_W-1:0];
      wr_mask_s = bus.wr_mask;
      wr_pix_s  = bus.wr_data;
    end
  end

  // Pixel array update; the array itself has no reset.
  always_ff @(posedge clk) begin
    if (wr_act_s) begin
      for (int ch = 0; ch < CH_NUM; ch++) begin
        if (wr_mask_s[ch]) begin
          mem_r[wr_idx_s][ch*CH_W +: CH_W] <= wr_pix_s[ch*CH_W +: CH_W];
        end
      end
    end
  end

  // Read lookup with write-first bypass; out-of-range addresses read as zero.
  always_comb begin
    rd_pix_s = '0;
    if (rd_in_range_s) begin
      if (wr_act_s && (wr_idx_s == rd_idx_s)) begin
        rd_pix_s = merge_pix(mem_r[rd_idx_s], wr_pix_s, wr_mask_s);
      end else begin
        rd_pix_s = mem_r[rd_idx_s];
      end
    end else begin
      rd_pix_s = '0;
    end
  end

  // First read stage: data holds between reads, valid follows rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_r <= rd_pix_s;
      end else begin
        rd_data_r <= rd_data_r;
      end
    end
  end

`ifdef FRAME_SRAM_OUTREG_EN
  logic [PIX_W-1:0] rd_data2_r;
  logic             rd_valid2_r;

  // Second read stage for timing closure, carrying valid alongside the data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data2_r  <= '0;
      rd_valid2_r <= 1'b0;
    end else begin
      rd_valid2_r <= rd_valid_r;
      if (rd_valid_r) begin
        rd_data2_r <= rd_data_r;
      end else begin
        rd_data2_r <= rd_data2_r;
      end
    end
  end

  assign bus.rd_data  = rd_data2_r;
  assign bus.rd_valid = rd_valid2_r;
`else
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
`endif

  assign bus.clr_busy = clr_busy_r;
  assign bus.clr_done = clr_done_r;
endmodule

// File: tb/tb_frame_sram_dp.sv
// Randomised scoreboard bench for frame_sram_dp on a 4x4 frame; a pixel-array reference
// model predicts read data and clear status, and a monitor compares them every cycle.
module tb_frame_sram_dp;
  localparam int AW    = 5;
  localparam int CHN   = 3;
  localparam int CW    = 8;
  localparam int PW    = CHN * CW;
  localparam int DEPTH = 16;
`ifdef FRAME_SRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  frame_sram_if #(.ADDR_SZ(AW), .CH_NUM(CHN), .CH_W(CW)) bus ();

  frame_sram_dp #(
    .IMG_W(4), .IMG_H(4), .ADDR_SZ(AW), .CH_NUM(CHN), .CH_W(CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { int due; logic [PW-1:0] data; } rd_exp_t;
  typedef struct { int due; logic busy; logic done; } st_exp_t;

  rd_exp_t rd_q[$];
  st_exp_t st_q[$];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: pixel array plus clear progress (0 idle, 1 clearing, 2 done pulse).
  logic [PW-1:0] ref_mem [DEPTH];
  int            ph   = 0;
  int            cidx = 0;
  logic [PW-1:0] cval = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_pix(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] rnd_pix();
    return PW'($urandom);
  endfunction

  // Monitor: every cycle out of reset, compare rd_valid/rd_data and clear status with the queues.
  always @(negedge clk) begin : monitor
    logic exp_v;
    if (rst_n) begin
      exp_v = (rd_q.size() > 0) && (rd_q[0].due == cyc);
      check_bit("rd_valid", bus.rd_valid, exp_v);
      if (exp_v) begin
        check_pix("rd_data", bus.rd_data, rd_q[0].data);
        void'(rd_q.pop_front());
      end
      if (st_q.size() > 0 && st_q[0].due == cyc) begin
        check_bit("clr_busy", bus.clr_busy, st_q[0].busy);
        check_bit("clr_done", bus.clr_done, st_q[0].done);
        void'(st_q.pop_front());
      end
    end
  end

  // One clock of stimulus; the model decides what the DUT must produce for it.
  task automatic step(input logic we, input logic [AW-1:0] wa, input logic [CHN-1:0] wm,
                      input logic [PW-1:0] wd, input logic re, input logic [AW-1:0] ra,
                      input logic cs, input logic [PW-1:0] cv);
    logic           do_w;
    int             widx;
    logic [PW-1:0]  wpix;
    logic [CHN-1:0] wmask;
    logic [PW-1:0]  rexp;
    int             c;
    @(posedge clk);
    #1;
    c = cyc;
    bus.wr_en = we;  bus.wr_addr = wa;  bus.wr_mask = wm;  bus.wr_data = wd;
    bus.rd_en = re;  bus.rd_addr = ra;  bus.clr_start = cs; bus.clr_value = cv;
    do_w = 1'b0; widx = 0; wpix = '0; wmask = '0;
    if (ph == 1) begin
      do_w = 1'b1; widx = cidx; wpix = cval; wmask = '1;
    end else if (we && int'(wa) < DEPTH) begin
      do_w = 1'b1; widx = int'(wa); wpix = wd; wmask = wm;
    end
    if (re) begin
      rexp = '0;
      if (int'(ra) < DEPTH) begin
        rexp = ref_mem[int'(ra)];
        if (do_w && widx == int'(ra)) begin
          for (int ch = 0; ch < CHN; ch++)
            if (wmask[ch]) rexp[ch*CW +: CW] = wpix[ch*CW +: CW];
        end
      end
      rd_q.push_back('{c + LAT, rexp});
    end
    if (do_w) begin
      for (int ch = 0; ch < CHN; ch++)
        if (wmask[ch]) ref_mem[widx][ch*CW +: CW] = wpix[ch*CW +: CW];
    end
    if (ph == 1) begin
      cidx++;
      ph = (cidx == DEPTH) ? 2 : 1;
    end else if (ph == 2) begin
      ph = 0;
    end else if (cs) begin
      ph = 1; cidx = 0; cval = cv;
    end else begin
      ph = 0;
    end
    st_q.push_back('{c + 1, (ph == 1), (ph == 2)});
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic rd(input int a);
    step(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0, '0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_mask = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.clr_start = 1'b0; bus.clr_value = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_pix("reset_rd_data", bus.rd_data, '0);
    check_bit("reset_rd_valid", bus.rd_valid, 1'b0);
    check_bit("reset_clr_busy", bus.clr_busy, 1'b0);
    check_bit("reset_clr_done", bus.clr_done, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 3'b111, rnd_pix(), 1'b0, '0, 1'b0, '0);

    // Full write then read, followed by an idle cycle.
    step(1'b1, 5'd5, 3'b111, 24'hA1B2C3, 1'b0, '0, 1'b0, '0);
    rd(5);
    idle();
    // Partial channel write.
    step(1'b1, 5'd7, 3'b111, 24'h112233, 1'b0, '0, 1'b0, '0);
    step(1'b1, 5'd7, 3'b010, 24'hFFFFFF, 1'b0, '0, 1'b0, '0);
    rd(7);
    // Same-cycle collision on one channel.
    step(1'b1, 5'd9, 3'b111, 24'h123456, 1'b0, '0, 1'b0, '0);
    step(1'b1, 5'd9, 3'b001, 24'h0000AA, 1'b1, 5'd9, 1'b0, '0);
    // Mask of zero, out-of-range write (aliases addr 4 in the low bits) and out-of-range reads.
    step(1'b1, 5'd4, 3'b000, 24'hDEAD00, 1'b1, 5'd4, 1'b0, '0);
    step(1'b1, 5'd20, 3'b111, 24'hBADBAD, 1'b0, '0, 1'b0, '0);
    rd(4);
    rd(DEPTH);
    rd(31);
    idle();

    // Frame clear: read the address being cleared each cycle, and try a user write mid-clear.
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 24'h808080);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 3) step(1'b1, 5'd3, 3'b111, 24'h000000, 1'b1, AW'(i), 1'b1, 24'h111111);
      else        step(1'b0, '0, '0, '0, 1'b1, AW'(i), 1'b0, '0);
    end
    idle();
    for (int i = 0; i < DEPTH; i++) rd(i);

    // Clear request together with a user write in the same idle cycle.
    step(1'b1, 5'd2, 3'b111, 24'hCAFE01, 1'b0, '0, 1'b1, 24'h0F0F0F);
    rd(2);
    repeat (DEPTH + 2) idle();

    // Random traffic with occasional clears.
    for (int n = 0; n < 400; n++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      wa = AW'($urandom_range(0, 19));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 19));
      step(1'($urandom), wa, CHN'($urandom), rnd_pix(), 1'($urandom), ra,
           ($urandom_range(0, 59) == 0), rnd_pix());
    end
    repeat (DEPTH + 4) idle();

    // Reset part-way through a clear: six pixels written, the rest keep old data.
    for (int i = 0; i < DEPTH; i++) step(1'b1, AW'(i), 3'b111, rnd_pix(), 1'b0, '0, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 24'h5A5A5A);
    while (cidx < 6) idle();
    @(posedge clk);
    #1;
    st_q.delete();
    rd_q.delete();
    rst_n = 1'b0;
    #1;
    check_bit("reset_mid_clear_busy", bus.clr_busy, 1'b0);
    check_bit("reset_mid_clear_done", bus.clr_done, 1'b0);
    ph = 0;
    cidx = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) rd(i);
    step(1'b0, '0, '0, '0, 1'b0, '0, 1'b1, 24'h3C3C3C);
    repeat (DEPTH + 2) idle();
    for (int i = 0; i < DEPTH; i++) rd(i);
    repeat (LAT + 2) idle();

    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL rd_drain: %0d reads never answered, expected 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
